// File: rtl/mcu_spi_pkg.sv
// Shared types for the cartridge-MCU SPI bus arbiter: FSM state encoding and owner ids.
package mcu_spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN_A,
        S_OWN_B,
        S_GUARD
    } MuxState;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/mcu_spi_mux_if.sv
// Bus bundle between the two SPI masters, the arbiter and the cartridge MCU pins.
interface mcu_spi_mux_if;

    logic nSelA;
    logic DoA;
    logic ClkRunA;
    logic ClkStretchA;
    logic DiA;
    logic GntA;

    logic nSelB;
    logic DoB;
    logic ClkRunB;
    logic ClkStretchB;
    logic DiB;
    logic GntB;

    logic MCU_nCS;
    logic MCU_MOSI;
    logic MCU_MISO;
    logic MCU_SCK;

    // Arbiter side
    modport slave (
        input  nSelA, DoA, ClkRunA, ClkStretchA,
        input  nSelB, DoB, ClkRunB, ClkStretchB,
        input  MCU_MISO,
        output DiA, GntA, DiB, GntB,
        output MCU_nCS, MCU_MOSI, MCU_SCK
    );

    // Requesting masters plus MCU model side
    modport master (
        output nSelA, DoA, ClkRunA, ClkStretchA,
        output nSelB, DoB, ClkRunB, ClkStretchB,
        output MCU_MISO,
        input  DiA, GntA, DiB, GntB,
        input  MCU_nCS, MCU_MOSI, MCU_SCK
    );

endinterface

// File: rtl/spi_clk_gate.sv
// Glitch-free SPI clock gate: enable captured on the falling edge, ANDed with the clock.
module spi_clk_gate (
    input  logic clk,
    input  logic rst_n,
    input  logic en_d,
    output logic gclk_c
);

    logic en_q;

    // Enable only moves while clk is low, so the gated clock never produces runt pulses
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_d;
        end
    end

    assign gclk_c = clk & en_q;

endmodule

// File: rtl/mcu_spi_mux.sv
// Round-robin arbiter of the cartridge-MCU SPI bus between the RTC engine (A) and generic engine (B).
// Optional stretch watchdog enabled by defining MCU_SPI_STRETCH_TIMEOUT_EN.
module mcu_spi_mux
    import mcu_spi_pkg::*;
#(
    parameter int unsigned CS_IDLE_CYCLES  = 2,
    parameter int unsigned STRETCH_TIMEOUT = 4096
) (
    input  logic          SClk,
    input  logic          nReset,
    mcu_spi_mux_if.slave  bus,
    output logic          BusBusy,
    output logic          StretchTimeout
);

    localparam int unsigned GW = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES) : 1;

    MuxState       state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic [GW-1:0] guard_cnt_q, guard_cnt_d;

    logic own_a_c, own_b_c;
    logic req_a_c, req_b_c;
    logic run_c, stretch_c, sck_en_c;
    logic timeout_c, blk_a_c, blk_b_c;
    MuxState release_state_c;

    assign own_a_c = (state_q == S_OWN_A);
    assign own_b_c = (state_q == S_OWN_B);
    assign req_a_c = ~bus.nSelA & ~blk_a_c;
    assign req_b_c = ~bus.nSelB & ~blk_b_c;
    assign release_state_c = (CS_IDLE_CYCLES > 0) ? S_GUARD : S_IDLE;

    assign bus.GntA = own_a_c;
    assign bus.GntB = own_b_c;
    assign BusBusy  = (state_q != S_IDLE);

    // Pin mux: owner sees the MCU directly, everything else is parked at idle levels
    always_comb begin
        bus.MCU_nCS  = 1'b1;
        bus.MCU_MOSI = 1'b1;
        bus.DiA      = 1'b1;
        bus.DiB      = 1'b1;
        run_c        = 1'b0;
        stretch_c    = 1'b0;
        if (own_a_c) begin
            bus.MCU_nCS  = bus.nSelA;
            bus.MCU_MOSI = bus.DoA;
            bus.DiA      = bus.MCU_MISO;
            run_c        = bus.ClkRunA;
            stretch_c    = bus.ClkStretchA;
        end else if (own_b_c) begin
            bus.MCU_nCS  = bus.nSelB;
            bus.MCU_MOSI = bus.DoB;
            bus.DiB      = bus.MCU_MISO;
            run_c        = bus.ClkRunB;
            stretch_c    = bus.ClkStretchB;
        end
    end

    assign sck_en_c = run_c & ~stretch_c;

`ifdef MCU_SPI_STRETCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(STRETCH_TIMEOUT + 1);

    logic [TW-1:0] stall_cnt_q, stall_cnt_d;
    logic          to_flag_q, to_flag_d;
    logic          blk_a_q, blk_a_d;
    logic          blk_b_q, blk_b_d;

    // A timed-out master stays locked out until it deasserts its select
    always_comb begin
        stall_cnt_d = '0;
        timeout_c   = 1'b0;
        to_flag_d   = to_flag_q;
        blk_a_d     = blk_a_q & ~bus.nSelA;
        blk_b_d     = blk_b_q & ~bus.nSelB;
        if (stretch_c) begin
            if (stall_cnt_q == TW'(STRETCH_TIMEOUT - 1)) begin
                timeout_c = 1'b1;
                to_flag_d = 1'b1;
                if (own_a_c) blk_a_d = 1'b1;
                if (own_b_c) blk_b_d = 1'b1;
            end else begin
                stall_cnt_d = stall_cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            stall_cnt_q <= '0;
            to_flag_q   <= 1'b0;
            blk_a_q     <= 1'b0;
            blk_b_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            to_flag_q   <= to_flag_d;
            blk_a_q     <= blk_a_d;
            blk_b_q     <= blk_b_d;
        end
    end

    assign StretchTimeout = to_flag_q;
    assign blk_a_c        = blk_a_q;
    assign blk_b_c        = blk_b_q;
`else
    logic unused_c;

    assign unused_c       = ^STRETCH_TIMEOUT;
    assign timeout_c      = 1'b0;
    assign blk_a_c        = 1'b0;
    assign blk_b_c        = 1'b0;
    assign StretchTimeout = 1'b0;
`endif

    // Next-state: grant in IDLE, release on deselect or timeout, hold nCS high through GUARD
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        guard_cnt_d  = guard_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_a_c && (!req_b_c || last_owner_q == OWN_B)) begin
                    state_d      = S_OWN_A;
                    last_owner_d = OWN_A;
                end else if (req_b_c) begin
                    state_d      = S_OWN_B;
                    last_owner_d = OWN_B;
                end
            end
            S_OWN_A: begin
                if (bus.nSelA || timeout_c) begin
                    state_d     = release_state_c;
                    guard_cnt_d = GW'(CS_IDLE_CYCLES - 1);
                end
            end
            S_OWN_B: begin
                if (bus.nSelB || timeout_c) begin
                    state_d     = release_state_c;
                    guard_cnt_d = GW'(CS_IDLE_CYCLES - 1);
                end
            end
            S_GUARD: begin
                if (guard_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= S_IDLE;
            last_owner_q <= OWN_B;
            guard_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            guard_cnt_q  <= guard_cnt_d;
        end
    end

    spi_clk_gate u_sck_gate (
        .clk    (SClk),
        .rst_n  (nReset),
        .en_d   (sck_en_c),
        .gclk_c (bus.MCU_SCK)
    );

endmodule

// File: tb/tb_mcu_spi_mux.sv
// Scoreboard bench for mcu_spi_mux: grant latency, round-robin, guard gap, SCK gating, async reset, stretch timeout.
module tb_mcu_spi_mux;

    logic SClk;
    logic nReset;
    logic BusBusy;
    logic StretchTimeout;

    mcu_spi_mux_if bus ();

    mcu_spi_mux #(
        .CS_IDLE_CYCLES  (2),
        .STRETCH_TIMEOUT (8)
    ) dut (
        .SClk           (SClk),
        .nReset         (nReset),
        .bus            (bus),
        .BusBusy        (BusBusy),
        .StretchTimeout (StretchTimeout)
    );

    initial SClk = 1'b0;
    always #5 SClk = ~SClk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    // Pulse counter and pulse-width monitor on the gated clock
    int  sck_pulses = 0;
    int  runt_cnt   = 0;
    time rise_t     = 0;

    always @(bus.MCU_SCK) begin
        if (bus.MCU_SCK === 1'b1) begin
            rise_t = $time;
            sck_pulses++;
        end else if (nReset && ($time - rise_t) != 5) begin
            runt_cnt++;
        end
    end

    task automatic tick();
        @(posedge SClk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.nSelA       = 1'b1;
        bus.DoA         = 1'b1;
        bus.ClkRunA     = 1'b0;
        bus.ClkStretchA = 1'b0;
        bus.nSelB       = 1'b1;
        bus.DoB         = 1'b1;
        bus.ClkRunB     = 1'b0;
        bus.ClkStretchB = 1'b0;
        bus.MCU_MISO    = 1'b1;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        idle_inputs();
        @(negedge SClk);
        #1;
        nReset = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(input bit want_b, input int limit, output int n);
        n = 0;
        while (((want_b ? bus.GntB : bus.GntA) !== 1'b1) && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        int p1;

        nReset = 1'b0;
        idle_inputs();
        #2;
        sb_push("reset_outs", 32'b0_0_1_1_0_1_1_0_0);
        sb_check({bus.GntA, bus.GntB, bus.MCU_nCS, bus.MCU_MOSI, bus.MCU_SCK,
                  bus.DiA, bus.DiB, BusBusy, StretchTimeout});
        @(negedge SClk);
        #1;
        nReset = 1'b1;
        tick();

        // Single request from A, non-owner B activity must not leak
        bus.nSelA    = 1'b0;
        bus.DoA      = 1'b0;
        bus.MCU_MISO = 1'b0;
        sb_push("gnt_single", 3'b101);
        tick();
        sb_check({bus.GntA, bus.GntB, BusBusy});
        sb_push("ncs_follow", 1'b0);
        sb_check(bus.MCU_nCS);
        bus.DoB     = 1'b1;
        bus.ClkRunB = 1'b1;
        sb_push("mosi_pass", 1'b0);
        sb_check(bus.MCU_MOSI);
        sb_push("di_route_lo", 2'b01);
        sb_check({bus.DiA, bus.DiB});
        bus.MCU_MISO = 1'b1;
        #1;
        sb_push("di_route_hi", 2'b11);
        sb_check({bus.DiA, bus.DiB});

        p0 = sck_pulses;
        bus.ClkRunA = 1'b1;
        sb_push("sck_16_pulses", 16);
        repeat (16) tick();
        bus.ClkRunA = 1'b0;
        repeat (2) tick();
        sb_check(sck_pulses - p0);
        bus.ClkRunB = 1'b0;

        // A releases while B requests on the same edge: guard keeps nCS high
        bus.nSelA = 1'b1;
        bus.nSelB = 1'b0;
        bus.DoB   = 1'b0;
        sb_push("gnt_release", 2'b00);
        tick();
        sb_check({bus.GntA, bus.GntB});
        sb_push("guard_ncs_high", 3);
        n = 0;
        while (bus.MCU_nCS === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        sb_check(n);
        sb_push("gnt_b_after_guard", 3'b010);
        sb_check({bus.GntA, bus.GntB, bus.MCU_MOSI});

        // Async reset in the high phase of an active SCK pulse
        bus.ClkRunB = 1'b1;
        tick();
        tick();
        sb_push("sck_before_rst", 1'b1);
        sb_check(bus.MCU_SCK);
        nReset = 1'b0;
        #1;
        sb_push("rst_async", 4'b0100);
        sb_check({bus.MCU_SCK, bus.MCU_nCS, bus.GntB, BusBusy});
        idle_inputs();
        @(negedge SClk);
        #1;
        nReset = 1'b1;
        tick();

        // Tie from reset goes to A, then round-robin
        bus.nSelA = 1'b0;
        bus.nSelB = 1'b0;
        sb_push("tie1_a_wins", 2'b10);
        tick();
        sb_check({bus.GntA, bus.GntB});
        bus.nSelA = 1'b1;
        sb_push("rr_b_cycles", 4);
        wait_gnt(1'b1, 10, n);
        sb_check(n);
        bus.nSelB = 1'b1;
        tick();
        bus.nSelA = 1'b0;
        bus.nSelB = 1'b0;
        sb_push("rr_a_cycles", 3);
        wait_gnt(1'b0, 10, n);
        sb_check(n);
        sb_push("tie2_a_wins", 2'b10);
        sb_check({bus.GntA, bus.GntB});
        bus.nSelB = 1'b1;

        // Stretch for 5 cycles mid-transfer removes exactly 5 pulses
        p0 = sck_pulses;
        bus.ClkRunA = 1'b1;
        repeat (4) tick();
        bus.ClkStretchA = 1'b1;
        p1 = sck_pulses;
        sb_push("stretch_gap", 0);
        repeat (5) tick();
        sb_check(sck_pulses - p1);
        bus.ClkStretchA = 1'b0;
        sb_push("stretch_total", 11);
        repeat (7) tick();
        bus.ClkRunA = 1'b0;
        repeat (2) tick();
        sb_check(sck_pulses - p0);
        sb_push("no_runt_pulse", 0);
        sb_check(runt_cnt);

`ifdef MCU_SPI_STRETCH_TIMEOUT_EN
        do_reset();
        bus.nSelA = 1'b0;
        tick();
        sb_push("to_gnt", 1'b1);
        sb_check(bus.GntA);
        bus.ClkRunA     = 1'b1;
        bus.ClkStretchA = 1'b1;
        sb_push("to_cycles", 8);
        n = 0;
        while (bus.GntA === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        sb_check(n);
        sb_push("to_flags", 3'b101);
        sb_check({StretchTimeout, bus.GntA, bus.MCU_nCS});
        bus.ClkRunA     = 1'b0;
        bus.ClkStretchA = 1'b0;
        sb_push("to_locked_out", 1'b0);
        repeat (10) tick();
        sb_check(bus.GntA);
        bus.nSelA = 1'b1;
        tick();
        bus.nSelA = 1'b0;
        sb_push("to_regrant_cycles", 1);
        wait_gnt(1'b0, 10, n);
        sb_check(n);
        sb_push("to_sticky", 1'b1);
        sb_check(StretchTimeout);
`else
        do_reset();
        bus.nSelA = 1'b0;
        tick();
        bus.ClkRunA     = 1'b1;
        bus.ClkStretchA = 1'b1;
        sb_push("no_timeout", 2'b01);
        repeat (20) tick();
        sb_check({StretchTimeout, bus.GntA});
`endif

        check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
